// File: rtl/ahb_master_arbiter.sv
// Round-robin arbiter sharing one AHB-Lite master port between NUM_REQ requesters, with lock and data-phase routing.
// Latency: grant and address phase are combinational (zero cycles); the response is routed in the following data phase.
// Backpressure: m_hready=0 holds the presented address phase and all arbitration state; requesters wait for req_ready.
module ahb_master_arbiter #(
    parameter int          NUM_REQ    = 2,
    parameter int          ADDR_WIDTH = 32,
    parameter int          DATA_WIDTH = 32,
    parameter logic [3:0]  HPROT_VAL  = 4'b0011
) (
    input  logic                             hclk,
    input  logic                             hresetn,
    input  logic [NUM_REQ-1:0]               req_valid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
    input  logic [NUM_REQ-1:0]               req_write,
    input  logic [NUM_REQ*3-1:0]             req_size,
    input  logic [NUM_REQ-1:0]               req_lock,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
    output logic [NUM_REQ-1:0]               req_ready,
    output logic [NUM_REQ-1:0]               rsp_valid,
    output logic [DATA_WIDTH-1:0]            rsp_rdata,
    output logic                             rsp_err,
    output logic [ADDR_WIDTH-1:0]            m_haddr,
    output logic [1:0]                       m_htrans,
    output logic                             m_hwrite,
    output logic [2:0]                       m_hsize,
    output logic [2:0]                       m_hburst,
    output logic [3:0]                       m_hprot,
    output logic                             m_hmastlock,
    output logic [DATA_WIDTH-1:0]            m_hwdata,
    input  logic [DATA_WIDTH-1:0]            m_hrdata,
    input  logic                             m_hready,
    input  logic                             m_hresp
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    // Arbitration state
    logic [IW-1:0]         rr_ptr;
    logic                  lock_q;
    logic                  hold_q;
    logic [IW-1:0]         grant_q;

    // Data-phase state
    logic                  dp_valid;
    logic [IW-1:0]         dp_owner;
    logic [DATA_WIDTH-1:0] dp_wdata;

    // Combinational arbitration and selected payload
    logic                  lock_eff;
    logic                  err_first;
    logic                  arb_vld;
    logic [IW-1:0]         arb_idx;
    logic [IW:0]           scan_sum;
    logic [IW-1:0]         scan_idx;
    logic                  grant_vld;
    logic [IW-1:0]         grant_idx;
    logic                  sel_valid;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic                  sel_write;
    logic [2:0]            sel_size;
    logic                  sel_lock;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic                  addr_vld;
    logic                  accept;
    logic [IW-1:0]         rr_next;

    // An error response in flight aborts any locked sequence, so the lock stops masking immediately.
    assign lock_eff  = lock_q & ~(dp_valid & m_hresp);
    // First cycle of the two-cycle ERROR response: the pending address phase must be cancelled.
    assign err_first = dp_valid & m_hresp & ~m_hready;

    // Round-robin scan starting at rr_ptr; while locked only the lock owner (last accepted) is eligible.
    always_comb begin
        arb_vld  = 1'b0;
        arb_idx  = '0;
        scan_sum = '0;
        scan_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            scan_sum = {1'b0, rr_ptr} + (IW+1)'(i);
            if (scan_sum >= (IW+1)'(NUM_REQ)) begin
                scan_sum = scan_sum - (IW+1)'(NUM_REQ);
            end
            scan_idx = scan_sum[IW-1:0];
            if (!arb_vld && req_valid[scan_idx] && (!lock_eff || scan_idx == dp_owner)) begin
                arb_vld = 1'b1;
                arb_idx = scan_idx;
            end
        end
    end

    // An address phase already on the bus and stalled by wait states keeps its owner, so the address stays stable;
    // otherwise (including IDLE during waits) a fresh arbitration result is presented.
    assign grant_vld = hold_q | arb_vld;
    assign grant_idx = hold_q ? grant_q : arb_idx;

    // Payload multiplexer for the granted requester.
    always_comb begin
        sel_valid = 1'b0;
        sel_addr  = '0;
        sel_write = 1'b0;
        sel_size  = '0;
        sel_lock  = 1'b0;
        sel_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_idx == IW'(i)) begin
                sel_valid = req_valid[i];
                sel_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_write = req_write[i];
                sel_size  = req_size[i*3 +: 3];
                sel_lock  = req_lock[i];
                sel_wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Reset gates the combinational address path so the bus shows IDLE the moment hresetn drops.
    assign addr_vld = hresetn & grant_vld & sel_valid & ~err_first;
    assign accept   = addr_vld & m_hready;
    assign rr_next  = (grant_idx == IW'(NUM_REQ-1)) ? '0 : grant_idx + IW'(1);

    // Address-phase bus outputs and per-requester handshakes.
    always_comb begin
        m_htrans    = addr_vld ? HTRANS_NONSEQ : HTRANS_IDLE;
        m_haddr     = addr_vld ? sel_addr  : '0;
        m_hwrite    = addr_vld ? sel_write : 1'b0;
        m_hsize     = addr_vld ? sel_size  : 3'b000;
        m_hmastlock = lock_eff | (addr_vld & sel_lock);
        req_ready   = '0;
        rsp_valid   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = accept && (grant_idx == IW'(i));
            rsp_valid[i] = dp_valid && m_hready && (dp_owner == IW'(i));
        end
    end

    assign rsp_rdata = m_hrdata;
    assign rsp_err   = dp_valid & m_hready & m_hresp;
    assign m_hwdata  = dp_wdata;
    assign m_hburst  = 3'b000;
    assign m_hprot   = HPROT_VAL;

    // Remember a stalled NONSEQ and its owner so the next cycle re-presents the same address phase.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            hold_q  <= 1'b0;
            grant_q <= '0;
        end else begin
            hold_q  <= addr_vld & ~m_hready;
            grant_q <= grant_idx;
        end
    end

    // Accept an address phase: open its data phase, advance the round-robin pointer and track the lock.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            rr_ptr   <= '0;
            lock_q   <= 1'b0;
            dp_valid <= 1'b0;
            dp_owner <= '0;
            dp_wdata <= '0;
        end else if (m_hready) begin
            if (accept) begin
                dp_valid <= 1'b1;
                dp_owner <= grant_idx;
                dp_wdata <= sel_wdata;
                rr_ptr   <= rr_next;
                lock_q   <= sel_lock;
            end else begin
                dp_valid <= 1'b0;
                if (dp_valid && m_hresp) begin
                    lock_q <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_ahb_master_arbiter.sv
// Self-checking bench for ahb_master_arbiter: directed scenarios followed by randomized traffic against a queue-free reference model.
// Latency: outputs are compared every cycle, 2 time units after inputs change at the falling edge.
// Backpressure: a scripted or randomized slave drives wait states and two-cycle ERROR responses.
module tb_ahb_master_arbiter;

    localparam int N = 2;

    logic              hclk = 1'b0;
    logic              hresetn;
    logic [N-1:0]      req_valid, req_write, req_lock, req_ready, rsp_valid;
    logic [N*32-1:0]   req_addr, req_wdata;
    logic [N*3-1:0]    req_size;
    logic [31:0]       rsp_rdata, m_haddr, m_hwdata, m_hrdata;
    logic              rsp_err, m_hwrite, m_hmastlock, m_hready, m_hresp;
    logic [1:0]        m_htrans;
    logic [2:0]        m_hsize, m_hburst;
    logic [3:0]        m_hprot;

    ahb_master_arbiter dut (
        .hclk(hclk), .hresetn(hresetn),
        .req_valid(req_valid), .req_addr(req_addr), .req_write(req_write), .req_size(req_size),
        .req_lock(req_lock), .req_wdata(req_wdata), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .m_haddr(m_haddr), .m_htrans(m_htrans), .m_hwrite(m_hwrite), .m_hsize(m_hsize),
        .m_hburst(m_hburst), .m_hprot(m_hprot), .m_hmastlock(m_hmastlock), .m_hwdata(m_hwdata),
        .m_hrdata(m_hrdata), .m_hready(m_hready), .m_hresp(m_hresp)
    );

    always #5 hclk = ~hclk;

    int total = 0;
    int bad   = 0;

    // Requester side: one pending request each; rmode 0 = drop after accept, 1 = reissue forever, 2 = random refill
    logic        rv[N];
    logic [31:0] ra[N], rd[N];
    logic        rw[N], rl[N];
    logic [2:0]  rs[N];
    int          rmode[N];

    logic        hr_drv, hp_drv;
    logic [31:0] hrdata_drv;

    // Reference model: whose turn it is, who holds the lock (-1 none), who owns a stalled address phase (-1 none),
    // and the transfer currently in its data phase.
    int          m_turn, m_lock, m_held, m_owner;
    bit          m_dp;
    logic [31:0] m_wdata;

    // Randomized slave state
    bit sl_busy, sl_err, sl_e1;
    int sl_waits;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int pick(input int live_lock);
        for (int k = 0; k < N; k++) begin
            int r = (m_turn + k) % N;
            if (rv[r] && (live_lock < 0 || r == live_lock)) return r;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_turn = 0; m_lock = -1; m_held = -1; m_owner = 0; m_dp = 0; m_wdata = '0;
        sl_busy = 0; sl_err = 0; sl_e1 = 0; sl_waits = 0;
    endtask

    task automatic new_req(input int i);
        rv[i] = 1'b1;
        ra[i] = $urandom() & 32'hFFFF_FFFC;
        rw[i] = 1'($urandom_range(0, 1));
        rs[i] = 3'($urandom_range(0, 2));
        rl[i] = ($urandom_range(0, 7) == 0);
        rd[i] = $urandom();
    endtask

    task automatic set_req(input int i, input logic [31:0] a, input logic w, input logic l, input logic [31:0] d);
        rv[i] = 1'b1; ra[i] = a; rw[i] = w; rl[i] = l; rs[i] = 3'd2; rd[i] = d;
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < N; i++) begin
            req_valid[i]         = rv[i];
            req_addr[i*32 +: 32] = ra[i];
            req_write[i]         = rw[i];
            req_size[i*3 +: 3]   = rs[i];
            req_lock[i]          = rl[i];
            req_wdata[i*32 +: 32]= rd[i];
        end
        m_hready = hr_drv;
        m_hresp  = hp_drv;
        m_hrdata = hrdata_drv;
    endtask

    // One bus cycle: drive at the falling edge, compare against the model, then advance the model past the rising edge.
    task automatic step(input bit auto_sl, input bit hr, input bit hp);
        int g, gs, live_lock;
        bit err1, ns, acc;
        logic [N-1:0] exp_rdy, exp_rsp;
        @(negedge hclk);
        hr_drv = hr; hp_drv = hp;
        if (auto_sl) begin
            hrdata_drv = $urandom();
            if (!m_dp) begin
                hr_drv = 1'b1; hp_drv = 1'b0; sl_busy = 0;
            end else begin
                if (!sl_busy) begin
                    sl_busy = 1; sl_waits = $urandom_range(0, 2);
                    sl_err = ($urandom_range(0, 7) == 0); sl_e1 = 0;
                end
                if (sl_waits > 0)          begin hr_drv = 1'b0; hp_drv = 1'b0; end
                else if (sl_err && !sl_e1) begin hr_drv = 1'b0; hp_drv = 1'b1; end
                else                       begin hr_drv = 1'b1; hp_drv = sl_err; end
            end
        end
        drive_inputs();
        #2;
        err1      = m_dp && hp_drv && !hr_drv;
        live_lock = (m_lock >= 0 && !(m_dp && hp_drv)) ? m_lock : -1;
        g         = (m_held >= 0) ? m_held : pick(live_lock);
        gs        = (g < 0) ? 0 : g;
        ns        = (g >= 0) && rv[gs] && !err1;
        acc       = ns && hr_drv;
        exp_rdy   = '0;
        if (acc) exp_rdy[gs] = 1'b1;
        exp_rsp   = '0;
        if (m_dp && hr_drv) exp_rsp[m_owner] = 1'b1;

        chk("htrans",    m_htrans,    ns ? 2'b10 : 2'b00);
        chk("haddr",     m_haddr,     ns ? ra[gs] : 32'h0);
        chk("hwrite",    m_hwrite,    ns ? rw[gs] : 1'b0);
        chk("hsize",     m_hsize,     ns ? rs[gs] : 3'd0);
        chk("hmastlock", m_hmastlock, (live_lock >= 0) || (ns && rl[gs]));
        chk("req_ready", req_ready,   exp_rdy);
        chk("rsp_valid", rsp_valid,   exp_rsp);
        chk("rsp_err",   rsp_err,     m_dp && hr_drv && hp_drv);
        chk("hwdata",    m_hwdata,    m_wdata);
        chk("rsp_rdata", rsp_rdata,   hrdata_drv);

        if (auto_sl && m_dp) begin
            if (hr_drv)             sl_busy = 0;
            else if (sl_waits > 0)  sl_waits--;
            else                    sl_e1 = 1;
        end
        m_held = (ns && !hr_drv) ? gs : -1;
        if (hr_drv) begin
            if (m_dp && hp_drv) m_lock = -1;
            if (acc) begin
                m_dp = 1; m_owner = gs; m_wdata = rd[gs];
                m_turn = (gs + 1) % N;
                m_lock = rl[gs] ? gs : -1;
                if (rmode[gs] != 1) rv[gs] = 1'b0;
                if (rmode[gs] == 2 && $urandom_range(0, 1) == 1) new_req(gs);
            end else begin
                m_dp = 0;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (rmode[i] == 2 && !rv[i] && $urandom_range(0, 1) == 1) new_req(i);
        end
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            rv[i] = 0; ra[i] = '0; rd[i] = '0; rw[i] = 0; rl[i] = 0; rs[i] = '0; rmode[i] = 0;
        end
        hr_drv = 1'b1; hp_drv = 1'b0; hrdata_drv = '0;
        model_reset();

        // Reset with a request already pending: the bus must stay IDLE
        hresetn = 1'b0;
        set_req(0, 32'h0000_0123, 1'b0, 1'b0, 32'h0);
        drive_inputs();
        repeat (2) @(negedge hclk);
        #2;
        chk("rst_htrans",    m_htrans,    2'b00);
        chk("rst_haddr",     m_haddr,     32'h0);
        chk("rst_req_ready", req_ready,   2'b00);
        chk("rst_rsp_valid", rsp_valid,   2'b00);
        chk("rst_hwdata",    m_hwdata,    32'h0);
        chk("rst_hmastlock", m_hmastlock, 1'b0);
        chk("rst_hburst",    m_hburst,    3'b000);
        chk("rst_hprot",     m_hprot,     4'b0011);
        rv[0] = 1'b0;
        drive_inputs();
        @(negedge hclk);
        hresetn = 1'b1;

        // Both requesters always valid: addresses alternate starting with requester 0
        rmode[0] = 1; rmode[1] = 1;
        set_req(0, 32'h100, 1'b0, 1'b0, 32'h0);
        set_req(1, 32'h200, 1'b0, 1'b0, 32'h0);
        for (int k = 0; k < 6; k++) begin
            step(0, 1, 0);
            chk("alt_haddr", m_haddr, (k % 2 == 1) ? 32'h200 : 32'h100);
        end
        rmode[0] = 0; rmode[1] = 0; rv[0] = 0; rv[1] = 0;
        step(0, 1, 0);

        // Zero-wait read returns data one cycle after accept
        set_req(0, 32'h80, 1'b0, 1'b0, 32'h0);
        step(0, 1, 0);
        chk("rd_accept", req_ready, 2'b01);
        hrdata_drv = 32'h1234_5678;
        step(0, 1, 0);
        chk("rd_rsp_valid", rsp_valid, 2'b01);
        chk("rd_rdata",     rsp_rdata, 32'h1234_5678);

        // Write with two wait states; the next address phase is held stable across them
        set_req(1, 32'h40, 1'b1, 1'b0, 32'hDEAD_BEEF);
        step(0, 1, 0);
        chk("wr_accept", req_ready, 2'b10);
        set_req(0, 32'h300, 1'b0, 1'b0, 32'h0);
        for (int k = 0; k < 3; k++) begin
            step(0, (k == 2), 0);
            chk("wr_hold_addr", m_haddr,  32'h300);
            chk("wr_hwdata",    m_hwdata, 32'hDEAD_BEEF);
            chk("wr_rsp_once",  rsp_valid, (k == 2) ? 2'b10 : 2'b00);
        end
        step(0, 1, 0);

        // Reset while a NONSEQ is stalled by wait states
        set_req(1, 32'h500, 1'b0, 1'b0, 32'h55);
        step(0, 1, 0);
        set_req(0, 32'h600, 1'b0, 1'b0, 32'h0);
        step(0, 0, 0);
        chk("pre_rst_htrans", m_htrans, 2'b10);
        #1 hresetn = 1'b0;
        #1;
        chk("midrst_htrans",    m_htrans,    2'b00);
        chk("midrst_haddr",     m_haddr,     32'h0);
        chk("midrst_hwdata",    m_hwdata,    32'h0);
        chk("midrst_req_ready", req_ready,   2'b00);
        chk("midrst_rsp_valid", rsp_valid,   2'b00);
        model_reset();
        @(negedge hclk);
        hresetn = 1'b1;
        step(0, 1, 0);
        chk("reissue_accept", req_ready, 2'b01);

        // Locked sequence of three requester-0 transfers while requester 1 waits
        rmode[1] = 1;
        set_req(1, 32'h800, 1'b0, 1'b0, 32'h0);
        set_req(0, 32'h700, 1'b0, 1'b1, 32'h0);
        step(0, 1, 0);
        chk("lk_first_r1", req_ready, 2'b10);
        for (int k = 0; k < 3; k++) begin
            step(0, 1, 0);
            chk("lk_r0_ready",   req_ready,   2'b01);
            chk("lk_hmastlock",  m_hmastlock, 1'b1);
            if (k == 0) set_req(0, 32'h704, 1'b0, 1'b1, 32'h0);
            if (k == 1) set_req(0, 32'h708, 1'b0, 1'b0, 32'h0);
        end
        rmode[1] = 0;
        step(0, 1, 0);
        chk("lk_then_r1",   req_ready,   2'b10);
        chk("lk_released",  m_hmastlock, 1'b0);

        // Two-cycle ERROR on a requester-0 read with requester 1 pending
        set_req(0, 32'h900, 1'b0, 1'b0, 32'h0);
        set_req(1, 32'hA00, 1'b0, 1'b0, 32'h0);
        step(0, 1, 0);
        step(0, 0, 1);
        chk("err_idle",      m_htrans,  2'b00);
        chk("err_no_ready",  req_ready, 2'b00);
        step(0, 1, 1);
        chk("err_rsp_valid", rsp_valid, 2'b01);
        chk("err_rsp_err",   rsp_err,   1'b1);
        chk("err_next_r1",   m_haddr,   32'hA00);
        step(0, 1, 0);

        // Randomized traffic with random wait states and errors
        for (int i = 0; i < N; i++) rmode[i] = 2;
        for (int k = 0; k < 3000; k++) step(1, 1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
